// File: rtl/dbus_pkg.sv
// Shared constants and types for the data-bus responder: MMIO offsets,
// STATUS bit positions and the UART transmitter state encoding.
package dbus_pkg;

    localparam logic [3:0] OFF_TXDATA  = 4'h0;
    localparam logic [3:0] OFF_STATUS  = 4'h4;
    localparam logic [3:0] OFF_BAUDDIV = 4'h8;
    localparam logic [3:0] OFF_CYCLE   = 4'hC;

    localparam int unsigned ST_FULL     = 0;
    localparam int unsigned ST_EMPTY    = 1;
    localparam int unsigned ST_BUSY     = 2;
    localparam int unsigned ST_OVF      = 3;
    localparam int unsigned ST_COUNT_LO = 8;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

endpackage

// File: rtl/dbus_responder_if.sv
// Core-side data bus: word address, store data/strobe and combinational load data.
interface dbus_responder_if;

    logic [31:0] addr;
    logic [31:0] write_data;
    logic        mem_write;
    logic [31:0] read_data;

    modport master (output addr, output write_data, output mem_write, input read_data);
    modport slave  (input addr, input write_data, input mem_write, output read_data);

endinterface

// File: rtl/uart_tx_engine.sv
// 8N1 serial transmitter: bit timer, shifter and frame FSM. Pulls one byte per
// frame from the FIFO via start/data while ready is high.
module uart_tx_engine
    import dbus_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  data,
    input  logic [15:0] baud,
    output logic        ready,
    output logic        uart_tx
);

    tx_state_e   state, state_n;
    logic [15:0] timer, timer_n;
    logic [15:0] baud_lat, baud_n;
    logic [7:0]  shift, shift_n;
    logic [2:0]  bit_idx, bit_n;
    logic        tx_n;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= TX_IDLE;
            timer    <= '0;
            baud_lat <= '0;
            shift    <= '0;
            bit_idx  <= '0;
            uart_tx  <= 1'b1;
        end else begin
            state    <= state_n;
            timer    <= timer_n;
            baud_lat <= baud_n;
            shift    <= shift_n;
            bit_idx  <= bit_n;
            uart_tx  <= tx_n;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_n = state;
        timer_n = timer;
        baud_n  = baud_lat;
        shift_n = shift;
        bit_n   = bit_idx;
        case (state)
            TX_IDLE: begin
                if (start) begin
                    shift_n = data;
                    baud_n  = baud;
                    timer_n = baud;
                    state_n = TX_START;
                end
            end
            default: begin
                // Divisor is frozen in baud_lat so mid-frame BAUDDIV writes wait for the next frame.
                if (timer != '0) begin
                    timer_n = timer - 1'b1;
                end else begin
                    timer_n = baud_lat;
                    case (state)
                        TX_START: begin
                            state_n = TX_DATA;
                            bit_n   = '0;
                        end
                        TX_DATA: begin
                            shift_n = {1'b0, shift[7:1]};
                            bit_n   = bit_idx + 1'b1;
                            if (bit_idx == 3'd7) state_n = TX_STOP;
                        end
                        default: state_n = TX_IDLE;
                    endcase
                end
            end
        endcase

        // Line level follows the next state so uart_tx comes straight from a flop.
        case (state_n)
            TX_START: tx_n = 1'b0;
            TX_DATA:  tx_n = shift_n[0];
            default:  tx_n = 1'b1;
        endcase
    end

    assign ready = (state == TX_IDLE);

endmodule

// File: rtl/dbus_responder.sv
// Data-bus responder: word RAM plus MMIO UART (TX FIFO, BAUDDIV, STATUS).
// Optional free-running cycle counter at offset 0xC when CYCLE_COUNTER_EN is defined.
module dbus_responder
    import dbus_pkg::*;
#(
    parameter int          RAM_WORDS  = 256,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] IO_BASE    = 32'h1000_0000,
    parameter logic [15:0] BAUD_RST   = 16'd433
) (
    input  logic             clk,
    input  logic             reset,
    dbus_responder_if.slave  bus,
    output logic             uart_tx,
    output logic             tx_irq
);

    localparam int RAM_AW  = $clog2(RAM_WORDS);
    localparam int FIFO_AW = $clog2(FIFO_DEPTH);

    logic              ram_sel, io_sel;
    logic [3:0]        io_off;
    logic [RAM_AW-1:0] ram_idx;
    logic              wr_ram, wr_io;
    logic              push_req, push, pop;
    logic              full, empty, busy, eng_ready;
    logic              ovf;
    logic [15:0]       baud;
    logic [31:0]       status_word, cycle_rd, rd;
    logic              unused_addr;

    logic [31:0]        ram [RAM_WORDS];
    logic [7:0]         fifo_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;

    assign unused_addr = ^bus.addr[1:0];

    assign ram_sel  = bus.addr < 32'(RAM_WORDS * 4);
    assign io_sel   = !ram_sel && (bus.addr[31:4] == IO_BASE[31:4]);
    assign io_off   = {bus.addr[3:2], 2'b00};
    assign ram_idx  = bus.addr[RAM_AW+1:2];
    assign wr_ram   = bus.mem_write && ram_sel;
    assign wr_io    = bus.mem_write && io_sel;
    assign push_req = wr_io && (io_off == OFF_TXDATA);

    assign full  = (count == (FIFO_AW+1)'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign busy  = !eng_ready;
    assign pop   = eng_ready && !empty;
    // A full FIFO still takes a push when the engine pops in the same cycle.
    assign push  = push_req && (!full || pop);

    // NOTE: storage arrays carry no reset; only control state is cleared.
    always_ff @(posedge clk) begin
        if (wr_ram) ram[ram_idx] <= bus.write_data;
        if (push)   fifo_mem[wr_ptr] <= bus.write_data[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            baud   <= BAUD_RST;
            tx_irq <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_req && full && !pop)
                ovf <= 1'b1;
            else if (wr_io && (io_off == OFF_STATUS) && bus.write_data[ST_OVF])
                ovf <= 1'b0;
            if (wr_io && (io_off == OFF_BAUDDIV))
                baud <= bus.write_data[15:0];
            tx_irq <= empty && !busy;
        end
    end

    uart_tx_engine u_tx (
        .clk     (clk),
        .reset   (reset),
        .start   (pop),
        .data    (fifo_mem[rd_ptr]),
        .baud    (baud),
        .ready   (eng_ready),
        .uart_tx (uart_tx)
    );

`ifdef CYCLE_COUNTER_EN
    logic [31:0] cycle_cnt;

    always_ff @(posedge clk) begin
        if (reset) cycle_cnt <= '0;
        else       cycle_cnt <= cycle_cnt + 32'd1;
    end

    assign cycle_rd = cycle_cnt;
`else
    assign cycle_rd = '0;
`endif

    always_comb begin
        status_word                   = '0;
        status_word[ST_FULL]          = full;
        status_word[ST_EMPTY]         = empty;
        status_word[ST_BUSY]          = busy;
        status_word[ST_OVF]           = ovf;
        status_word[ST_COUNT_LO +: 4] = 4'(count);
    end

    always_comb begin
        rd = '0;
        if (ram_sel) begin
            rd = ram[ram_idx];
        end else if (io_sel) begin
            case (io_off)
                OFF_STATUS:  rd = status_word;
                OFF_BAUDDIV: rd = {16'b0, baud};
                OFF_CYCLE:   rd = cycle_rd;
                default:     rd = '0;
            endcase
        end
    end

    assign bus.read_data = rd;

endmodule
